// File: rtl/led_panel_fb_arbiter.sv
// ---------------------------------------------------------------------------
// led_panel_fb_arbiter
//
// Owns the LED panel framebuffer (ROWS words of 3*COLS bits, one port,
// registered read output). The port is shared between the panel scan engine
// and REQUESTERS pixel writers. A scan row read always takes the port.
// Writers are granted round-robin. Each write is a read-modify-write of one
// row, sequenced by a small FSM in the single clock domain.
//
// Optional feature: define LED_PANEL_FB_CLEAR_EN to add i_clear and the
// S_CLEAR state, which zeroes every row while scan reads keep priority.
//
// Ports:
//   i_clock            single clock
//   i_reset            synchronous, active-high reset
//   i_clear            (LED_PANEL_FB_CLEAR_EN only) start a framebuffer clear
//   i_req_valid        per-writer request, held with its payload until ready
//   o_req_ready        one-hot accept strobe (combinational)
//   i_req_x/y/rgb/op   per-writer payload; slice k belongs to writer k
//                      op: 00 write, 01 set, 10 clear, 11 toggle
//   i_scan_valid       scan engine row read request
//   i_scan_row         row to read
//   o_scan_data        {blue, green, red} planes of the row, COLS bits each
//   o_scan_data_valid  one-cycle pulse, one cycle after the scan request
//   o_busy             FSM is not idle
// ---------------------------------------------------------------------------
package led_panel_fb_pkg;
  function automatic int bits_for(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((n >> i) != 0) r = i + 1;
    end
    return r;
  endfunction
endpackage

module led_panel_fb_arbiter
  import led_panel_fb_pkg::*;
#(
  parameter int COLS       = 32,
  parameter int ROWS       = 16,
  parameter int REQUESTERS = 3,
  parameter int COL_BITS   = bits_for(COLS - 1),
  parameter int ROW_BITS   = bits_for(ROWS - 1)
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
`ifdef LED_PANEL_FB_CLEAR_EN
  input  logic                           i_clear,
`endif
  input  logic [REQUESTERS-1:0]          i_req_valid,
  output logic [REQUESTERS-1:0]          o_req_ready,
  input  logic [REQUESTERS*COL_BITS-1:0] i_req_x,
  input  logic [REQUESTERS*ROW_BITS-1:0] i_req_y,
  input  logic [REQUESTERS*3-1:0]        i_req_rgb,
  input  logic [REQUESTERS*2-1:0]        i_req_op,
  input  logic                           i_scan_valid,
  input  logic [ROW_BITS-1:0]            i_scan_row,
  output logic [3*COLS-1:0]              o_scan_data,
  output logic                           o_scan_data_valid,
  output logic                           o_busy
);

  localparam int ROW_W  = 3 * COLS;
  localparam int IDX_W  = bits_for(REQUESTERS - 1);
  localparam int RIDX_W = bits_for(ROW_W - 1);
  localparam logic [COL_BITS:0] L_COLS = (COL_BITS + 1)'(COLS);

`ifdef LED_PANEL_FB_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_MODIFY, S_WRITE, S_CLEAR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_MODIFY, S_WRITE} state_t;
`endif

  state_t              r_state, w_next;
  logic [IDX_W-1:0]    r_last_grant, w_gnt_idx, w_cand;
  logic                w_any, w_accept, w_oob, w_clear_req;
  logic                w_mem_rd, w_mem_we;
  logic [COL_BITS-1:0] w_sel_x, r_x;
  logic [ROW_BITS-1:0] w_sel_y, r_y;
  logic [2:0]          w_sel_rgb, r_rgb;
  logic [1:0]          w_sel_op, r_op;
  logic [ROW_W-1:0]    r_mem [ROWS];
  logic [ROW_W-1:0]    r_rd_data, r_row, w_wr_data;
  logic [ROW_BITS-1:0] w_wr_row;
  logic                r_scan_vld;

  function automatic logic bit_op(input logic b, input logic v, input logic [1:0] op);
    case (op)
      2'b00:   return v;
      2'b01:   return b | v;
      2'b10:   return b & ~v;
      default: return b ^ v;
    endcase
  endfunction

  // Apply op to column x of each colour plane; other bits pass through.
  function automatic logic [ROW_W-1:0] apply_op(input logic [ROW_W-1:0] row,
                                                input logic [COL_BITS-1:0] x,
                                                input logic [2:0] rgb,
                                                input logic [1:0] op);
    logic [ROW_W-1:0]  res;
    logic [RIDX_W-1:0] idx_r, idx_g, idx_b;
    res   = row;
    idx_r = RIDX_W'(x);
    idx_g = RIDX_W'(COLS) + RIDX_W'(x);
    idx_b = RIDX_W'(2 * COLS) + RIDX_W'(x);
    res[idx_r] = bit_op(row[idx_r], rgb[0], op);
    res[idx_g] = bit_op(row[idx_g], rgb[1], op);
    res[idx_b] = bit_op(row[idx_b], rgb[2], op);
    return res;
  endfunction

`ifdef LED_PANEL_FB_CLEAR_EN
  logic [ROW_BITS-1:0] r_clr_row;
  assign w_clear_req = i_clear;
`else
  assign w_clear_req = 1'b0;
`endif

  // Round-robin: first valid index after the last grant, wrapping.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      w_cand = IDX_W'((int'(r_last_grant) + i) % REQUESTERS);
      if (!w_any && i_req_valid[w_cand]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_sel_x   = i_req_x[w_gnt_idx*COL_BITS +: COL_BITS];
  assign w_sel_y   = i_req_y[w_gnt_idx*ROW_BITS +: ROW_BITS];
  assign w_sel_rgb = i_req_rgb[w_gnt_idx*3 +: 3];
  assign w_sel_op  = i_req_op[w_gnt_idx*2 +: 2];
  // Zero-extended compare so a power-of-two COLS does not fold to a constant.
  assign w_oob     = {1'b0, w_sel_x} >= L_COLS;

  // FSM: state register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_clear_req) begin
`ifdef LED_PANEL_FB_CLEAR_EN
          w_next = S_CLEAR;
`endif
        end else if (w_accept && !w_oob) begin
          w_next = S_READ;
        end
      end
      S_READ:   if (!i_scan_valid) w_next = S_MODIFY;
      S_MODIFY: w_next = S_WRITE;
      S_WRITE:  if (!i_scan_valid) w_next = S_IDLE;
`ifdef LED_PANEL_FB_CLEAR_EN
      S_CLEAR:  if (!i_scan_valid && r_clr_row == ROW_BITS'(ROWS - 1)) w_next = S_IDLE;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM: outputs and memory port control
  always_comb begin
    o_req_ready = '0;
    w_accept    = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_we    = 1'b0;
    w_wr_row    = r_y;
    w_wr_data   = r_row;
    case (r_state)
      S_IDLE: begin
        if (!i_scan_valid && !w_clear_req && w_any) begin
          w_accept               = 1'b1;
          o_req_ready[w_gnt_idx] = 1'b1;
        end
      end
      S_READ:  w_mem_rd = !i_scan_valid;
      // Reset on the commit edge drops the in-flight write.
      S_WRITE: w_mem_we = !i_scan_valid && !i_reset;
`ifdef LED_PANEL_FB_CLEAR_EN
      S_CLEAR: begin
        w_mem_we  = !i_scan_valid && !i_reset;
        w_wr_row  = r_clr_row;
        w_wr_data = '0;
      end
`endif
      default: ;
    endcase
  end

  assign o_busy            = (r_state != S_IDLE);
  assign o_scan_data       = r_rd_data;
  assign o_scan_data_valid = r_scan_vld;

  // Control registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_grant <= IDX_W'(REQUESTERS - 1);
      r_scan_vld   <= 1'b0;
    end else begin
      r_scan_vld <= i_scan_valid;
      if (w_accept) r_last_grant <= w_gnt_idx;
    end
  end

`ifdef LED_PANEL_FB_CLEAR_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_clr_row <= '0;
    end else if (r_state == S_IDLE) begin
      r_clr_row <= '0;
    end else if (r_state == S_CLEAR && !i_scan_valid) begin
      r_clr_row <= r_clr_row + 1'b1;
    end
  end
`endif

  // Request payload latch and row modify
  always_ff @(posedge i_clock) begin
    if (w_accept) begin
      r_x   <= w_sel_x;
      r_y   <= w_sel_y;
      r_rgb <= w_sel_rgb;
      r_op  <= w_sel_op;
    end
    if (r_state == S_MODIFY) r_row <= apply_op(r_rd_data, r_x, r_rgb, r_op);
  end

  // Memory port: scan read wins; the read register doubles as scan output.
  always_ff @(posedge i_clock) begin
    if (i_reset)           r_rd_data <= '0;
    else if (i_scan_valid) r_rd_data <= r_mem[i_scan_row];
    else if (w_mem_rd)     r_rd_data <= r_mem[r_y];
  end

  always_ff @(posedge i_clock) begin
    if (w_mem_we) r_mem[w_wr_row] <= w_wr_data;
  end

endmodule

// File: tb/tb_led_panel_fb_arbiter.sv
module tb_led_panel_fb_arbiter;
  localparam int COLS = 32, COLS_N = 20, ROWS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, scan, clear;
  logic [2:0]  valid;
  logic [14:0] req_x;
  logic [11:0] req_y;
  logic [8:0]  req_rgb;
  logic [5:0]  req_op;
  logic [3:0]  scan_row;
  logic [2:0]  ready_m, ready_n, ready;
  logic [95:0] data_m, data;
  logic [59:0] data_n;
  logic        sv_m, sv_n, sv, busy_m, busy_n, busy;

  assign ready = sel ? ready_n : ready_m;
  assign data  = sel ? {36'd0, data_n} : data_m;
  assign sv    = sel ? sv_n : sv_m;
  assign busy  = sel ? busy_n : busy_m;

  led_panel_fb_arbiter u_dut (
    .i_clock(clk), .i_reset(rst),
`ifdef LED_PANEL_FB_CLEAR_EN
    .i_clear(clear),
`endif
    .i_req_valid(sel ? 3'b000 : valid), .o_req_ready(ready_m),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_rgb(req_rgb), .i_req_op(req_op),
    .i_scan_valid(scan & ~sel), .i_scan_row(scan_row),
    .o_scan_data(data_m), .o_scan_data_valid(sv_m), .o_busy(busy_m));

  led_panel_fb_arbiter #(.COLS(COLS_N)) u_dut_n (
    .i_clock(clk), .i_reset(rst),
`ifdef LED_PANEL_FB_CLEAR_EN
    .i_clear(1'b0),
`endif
    .i_req_valid(sel ? valid : 3'b000), .o_req_ready(ready_n),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_rgb(req_rgb), .i_req_op(req_op),
    .i_scan_valid(scan & sel), .i_scan_row(scan_row),
    .o_scan_data(data_n), .o_scan_data_valid(sv_n), .o_busy(busy_n));

  // Reference model: framebuffer contents per DUT and the round-robin pointer.
  logic [95:0] mm [2][ROWS];
  int          mlast;
  int          px [3], py [3], prgb [3], pop [3];
  int          checks = 0, errors = 0;

  function automatic logic [95:0] model_apply(input logic [95:0] row, input int cols,
                                              input int x, input int rgb, input int op);
    logic [95:0] r, plane, pm, m, v;
    if (x >= cols) return row;
    r  = row;
    pm = (96'd1 << cols) - 96'd1;
    m  = 96'd1 << x;
    for (int p = 0; p < 3; p++) begin
      plane = (row >> (p * cols)) & pm;
      v = ((rgb >> p) & 1) != 0 ? m : 96'd0;
      case (op)
        0: plane = (plane & ~m) | v;
        1: plane = plane | v;
        2: plane = plane & ~v;
        default: plane = plane ^ v;
      endcase
      r = (r & ~(pm << (p * cols))) | (plane << (p * cols));
    end
    return r;
  endfunction

  function automatic int cols_of();
    return sel ? COLS_N : COLS;
  endfunction

  function automatic int rr_next(input int last, input logic [2:0] mask);
    for (int i = 1; i <= 3; i++) if (mask[(last + i) % 3]) return (last + i) % 3;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_req(input int k);
    req_x[k*5 +: 5]   = 5'(px[k]);
    req_y[k*4 +: 4]   = 4'(py[k]);
    req_rgb[k*3 +: 3] = 3'(prgb[k]);
    req_op[k*2 +: 2]  = 2'(pop[k]);
  endtask

  task automatic rand_req(input int k);
    px[k] = $urandom_range(0, 31); py[k] = $urandom_range(0, 15);
    prgb[k] = $urandom_range(0, 7); pop[k] = $urandom_range(0, 3);
    load_req(k);
  endtask

  task automatic expect_busy(input int n);
    for (int c = 0; c < n; c++) begin
      chk("busy_hi", busy, 1);
      @(posedge clk); #1;
    end
    chk("busy_lo", busy, 0);
  endtask

  // Called at #1 after a posedge with the FSM idle.
  task automatic write_req(input int k, input int x, input int y, input int rgb, input int op);
    px[k] = x; py[k] = y; prgb[k] = rgb; pop[k] = op;
    load_req(k);
    valid = 3'(1 << k);
    @(negedge clk);
    chk("wr_ready", ready, 96'(1 << k));
    @(posedge clk); #1;
    valid = 3'b000;
    if (x >= cols_of()) chk("oob_idle", busy, 0);
    else expect_busy(3);
    mm[sel][y] = model_apply(mm[sel][y], cols_of(), x, rgb, op);
    if (!sel) mlast = k;
  endtask

  task automatic scan_check(input int y);
    scan = 1'b1; scan_row = 4'(y);
    @(posedge clk); #1;
    chk("scan_vld", sv, 1);
    chk("scan_data", data, mm[sel][y]);
    scan = 1'b0;
    @(posedge clk); #1;
    chk("scan_pulse", sv, 0);
  endtask

  initial begin
    int grants, cyc, last_cyc, idx, n, wy;
    logic [2:0] mask;
    rst = 1'b1; sel = 1'b0; scan = 1'b0; clear = 1'b0; valid = '0;
    req_x = '0; req_y = '0; req_rgb = '0; req_op = '0; scan_row = '0;
    for (int d = 0; d < 2; d++) for (int r = 0; r < ROWS; r++) mm[d][r] = '0;
    mlast = 2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_scan_vld", sv, 0);
    chk("rst_scan_data", data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;

    // All writers valid continuously: rotating grants, 4 cycles apart.
    for (int k = 0; k < 3; k++) rand_req(k);
    valid = 3'b111; grants = 0; cyc = 0; last_cyc = 0;
    while (grants < 7 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (ready !== 3'b000) begin
        idx = rr_next(mlast, 3'b111);
        chk("rr_grant", ready, 96'(1 << idx));
        if (grants > 0) chk("rr_spacing", 96'(cyc - last_cyc), 4);
        last_cyc = cyc; mlast = idx; grants++;
        @(posedge clk); #1;
        rand_req(idx);
      end
    end
    chk("rr_grants", 96'(grants), 7);
    valid = 3'b000; n = 0;
    while (busy && n < 10) begin @(posedge clk); #1; n++; end
    chk("rr_drain", busy, 0);

    // Fill the whole framebuffer with known random pixels.
    for (int r = 0; r < ROWS; r++)
      for (int x = 0; x < COLS; x++)
        write_req($urandom_range(0, 2), x, r, $urandom_range(0, 7), 0);
    for (int r = 0; r < ROWS; r++) scan_check(r);

    // Single pixel write at (5,3) with rgb=101.
    write_req(0, 5, 3, 3'b101, 0);
    scan_check(3);
    chk("px53_red", data_m[5], 1);
    chk("px53_green", data_m[COLS + 5], 0);
    chk("px53_blue", data_m[2*COLS + 5], 1);

    // Corner pixel (31,15): set green then toggle green.
    write_req(0, 31, 15, 3'b010, 1);
    write_req(1, 31, 15, 3'b010, 3);
    scan_check(15);
    chk("corner_green", data_m[2*COLS - 1], 0);

    // Random request subsets and operations.
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 3; k++) rand_req(k);
      mask = 3'($urandom_range(1, 7));
      valid = mask;
      idx = rr_next(mlast, mask);
      @(negedge clk);
      chk("rr_rand", ready, 96'(1 << idx));
      @(posedge clk); #1;
      valid = 3'b000;
      mm[0][py[idx]] = model_apply(mm[0][py[idx]], COLS, px[idx], prgb[idx], pop[idx]);
      mlast = idx;
      expect_busy(3);
    end
    for (int r = 0; r < ROWS; r++) scan_check(r);

    // Scan held 3 cycles while a write sits in S_READ; scans see pre-write data.
    rand_req(2); wy = py[2];
    valid = 3'b100;
    @(negedge clk);
    chk("stall_ready", ready, 3'b100);
    @(posedge clk); #1;
    valid = 3'b000; mlast = 2;
    for (int i = 0; i < 3; i++) begin
      n = (i == 0) ? wy : $urandom_range(0, 15);
      scan = 1'b1; scan_row = 4'(n);
      @(posedge clk); #1;
      chk("stall_scan_vld", sv, 1);
      chk("stall_scan_data", data, mm[0][n]);
    end
    scan = 1'b0;
    expect_busy(3);
    chk("stall_scan_end", sv, 0);
    mm[0][wy] = model_apply(mm[0][wy], COLS, px[2], prgb[2], pop[2]);
    scan_check(wy);

    // Reset while the write is in S_WRITE: row keeps its old value.
    px[1] = 7; py[1] = 9; prgb[1] = 7; pop[1] = 3; load_req(1);
    valid = 3'b010;
    @(negedge clk);
    chk("rst_mid_ready", ready, 3'b010);
    @(posedge clk); #1;
    valid = 3'b000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mlast = 2;
    chk("rst_mid_busy", busy, 0);
    scan_check(9);
    for (int k = 0; k < 3; k++) rand_req(k);
    valid = 3'b111;
    @(negedge clk);
    chk("rst_grant0", ready, 3'b001);
    @(posedge clk); #1;
    valid = 3'b000;
    mm[0][py[0]] = model_apply(mm[0][py[0]], COLS, px[0], prgb[0], pop[0]);
    mlast = 0;
    expect_busy(3);
    scan_check(py[0]);

`ifdef LED_PANEL_FB_CLEAR_EN
    // Clear has priority over a waiting writer and zeroes every row.
    rand_req(0);
    valid = 3'b001; clear = 1'b1;
    @(negedge clk);
    chk("clr_ready", ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; valid = 3'b000; n = 0;
    while (busy && n < 40) begin n++; @(posedge clk); #1; end
    chk("clr_busy_cycles", 96'(n), 16);
    for (int r = 0; r < ROWS; r++) mm[0][r] = '0;
    for (int r = 0; r < ROWS; r++) scan_check(r);
`endif

    // Narrow instance (COLS=20): x beyond the panel is accepted and dropped.
    @(posedge clk); #1;
    sel = 1'b1;
    for (int x = 0; x < COLS_N; x++) write_req(x % 3, x, 2, $urandom_range(0, 7), 0);
    scan_check(2);
    write_req(0, 25, 2, 7, 0);
    write_req(1, 4, 2, 7, 3);
    scan_check(2);
    write_req(2, 31, 2, 7, 1);
    scan_check(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
